// File: rtl/sda_kernel_param_pkg.sv
// Shared types and address helpers for the kernel parameter store.
// Depth and index width are derived from the decoded byte window.
package sda_kernel_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_ACK  = 2'd2
    } reg_state_e;

    function automatic int unsigned param_depth(input int unsigned base_addr,
                                                input int unsigned top_addr);
        return (top_addr + 1 - base_addr) / 4;
    endfunction

    function automatic int unsigned param_idx_w(input int unsigned base_addr,
                                                input int unsigned top_addr);
        int unsigned depth;
        depth = param_depth(base_addr, top_addr);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input int unsigned base_addr,
                                           input int unsigned top_addr);
        return (addr >= base_addr) && (addr <= top_addr);
    endfunction

    // Byte offset bits [1:0] drop out of the shift.
    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input int unsigned base_addr);
        return (addr - base_addr) >> 2;
    endfunction

endpackage

// File: rtl/sda_kernel_param_ram.sv
// Single-port word RAM, 4 byte-lane write enables, registered read data.
// One-cycle read latency; read data holds until the next read; no reset.
module sda_kernel_param_ram #(
    parameter int unsigned DEPTH = 1008,
    parameter int unsigned IDX_W = 10
) (
    input  logic             clk,
    input  logic             en,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we == 4'b0000) begin
                rdata_q <= mem_q[addr];
            end
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sda_kernel_param_store.sv
// Kernel parameter store: host register window + kernel lookup port on one RAM.
// Reg write ack N+1, read ack N+2, lookup result N+1; register port stalls lookups.
module sda_kernel_param_store
    import sda_kernel_param_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned BASE_ADDR  = 64,
    parameter int unsigned TOP_ADDR   = 4095
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_req,
    output logic                  reg_ack,
    input  logic                  reg_write_en,
    input  logic [ADDR_WIDTH-1:0] reg_addr,
    input  logic [31:0]           reg_wdata,
    input  logic [3:0]            reg_wstrb,
    output logic [31:0]           reg_rdata,
    input  logic                  param_addr_valid,
    input  logic [31:0]           param_addr,
    output logic                  param_addr_stop,
    output logic                  param_data_valid,
    output logic [31:0]           param_data,
    input  logic                  param_data_stop
);

    localparam int unsigned DEPTH = param_depth(BASE_ADDR, TOP_ADDR);
    localparam int unsigned IDX_W = param_idx_w(BASE_ADDR, TOP_ADDR);

    reg_state_e       state_q, state_d;
    logic             rd_q, rd_d;
    logic             pdv_q, pdv_d;
    logic             fresh_q, fresh_d;
    logic             oor_q, oor_d;
    logic [31:0]      pdata_q, pdata_d;

    logic [31:0]      reg_addr_w;
    logic             reg_in_range, lk_in_range, reg_hit, lk_accept, lk_pop;
    logic [IDX_W-1:0] reg_idx, lk_idx;

    logic             ram_en;
    logic [3:0]       ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [31:0]      ram_rdata;

    assign reg_addr_w   = 32'(reg_addr);
    assign reg_in_range = addr_in_range(reg_addr_w, BASE_ADDR, TOP_ADDR);
    assign lk_in_range  = addr_in_range(param_addr, BASE_ADDR, TOP_ADDR);
    assign reg_idx      = IDX_W'(word_index(reg_addr_w, BASE_ADDR));
    assign lk_idx       = IDX_W'(word_index(param_addr, BASE_ADDR));

    assign reg_hit         = (state_q == ST_IDLE) && reg_req && reg_in_range;
    assign param_addr_stop = (state_q != ST_IDLE) || reg_hit || (pdv_q && param_data_stop);
    assign lk_accept       = param_addr_valid && !param_addr_stop;
    assign lk_pop          = pdv_q && !param_data_stop;

    assign reg_ack   = (state_q == ST_ACK);
    assign reg_rdata = (state_q == ST_ACK && rd_q) ? ram_rdata : 32'h0;

    // A fresh result is taken straight from the RAM output, then parked in pdata_q
    // so later register reads of the RAM cannot disturb a stalled result.
    assign param_data       = fresh_q ? (oor_q ? 32'h0 : ram_rdata) : pdata_q;
    assign param_data_valid = pdv_q;

    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 4'b0000;
        ram_addr = reg_idx;
        if (reg_hit) begin
            ram_en = 1'b1;
            ram_we = reg_write_en ? reg_wstrb : 4'b0000;
        end else if (lk_accept && lk_in_range) begin
            ram_en   = 1'b1;
            ram_addr = lk_idx;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (reg_hit) begin
                    rd_d    = !reg_write_en;
                    state_d = reg_write_en ? ST_ACK : ST_RD;
                end
            end
            ST_RD:   state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pdv_d   = lk_accept ? 1'b1 : (lk_pop ? 1'b0 : pdv_q);
        fresh_d = lk_accept;
        oor_d   = lk_accept && !lk_in_range;
        pdata_d = param_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rd_q    <= 1'b0;
            pdv_q   <= 1'b0;
            fresh_q <= 1'b0;
            oor_q   <= 1'b0;
            pdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            pdv_q   <= pdv_d;
            fresh_q <= fresh_d;
            oor_q   <= oor_d;
            pdata_q <= pdata_d;
        end
    end

    sda_kernel_param_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (reg_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_sda_kernel_param_store.sv
// Bench for sda_kernel_param_store: register vector table, hand corner cases,
// and randomized lookups scored against a word-array model with a result queue.
module tb_sda_kernel_param_store;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_req, reg_ack, reg_write_en;
    logic [11:0] reg_addr;
    logic [31:0] reg_wdata, reg_rdata;
    logic [3:0]  reg_wstrb;
    logic        param_addr_valid, param_addr_stop, param_data_valid, param_data_stop;
    logic [31:0] param_addr, param_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [int];
    logic [31:0] q [$];

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] want;
    } vec_t;

    vec_t vt [10];

    always #5 clk = ~clk;

    sda_kernel_param_store dut (
        .clk              (clk),
        .reset            (reset),
        .reg_req          (reg_req),
        .reg_ack          (reg_ack),
        .reg_write_en     (reg_write_en),
        .reg_addr         (reg_addr),
        .reg_wdata        (reg_wdata),
        .reg_wstrb        (reg_wstrb),
        .reg_rdata        (reg_rdata),
        .param_addr_valid (param_addr_valid),
        .param_addr       (param_addr),
        .param_addr_stop  (param_addr_stop),
        .param_data_valid (param_data_valid),
        .param_data       (param_data),
        .param_data_stop  (param_data_stop)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, want);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %b required %b", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return (a >= 32'd64) && (a <= 32'd4095);
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        int idx;
        if (!in_rng(a)) return 32'h0;
        idx = int'((a - 32'd64) >> 2);
        return mdl.exists(idx) ? mdl[idx] : 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        logic [31:0] w;
        if (!in_rng(a)) return;
        idx = int'((a - 32'd64) >> 2);
        w = mdl.exists(idx) ? mdl[idx] : 32'h0;
        for (int b = 0; b < 4; b++)
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        mdl[idx] = w;
    endtask

    task automatic reg_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        reg_req = 1'b1; reg_write_en = 1'b1; reg_addr = a; reg_wdata = d; reg_wstrb = s;
        #1;
        chkb("wr_ack_early", reg_ack, 1'b0);
        step();
        chkb("wr_ack", reg_ack, 1'b1);
        chk("wr_rdata_zero", reg_rdata, 32'h0);
        reg_req = 1'b0;
        step();
        chkb("wr_ack_drop", reg_ack, 1'b0);
        model_write(32'(a), d, s);
    endtask

    task automatic reg_read(input logic [11:0] a, input logic [31:0] want);
        reg_req = 1'b1; reg_write_en = 1'b0; reg_addr = a;
        #1;
        chkb("rd_ack_n", reg_ack, 1'b0);
        chk("rd_rdata_n", reg_rdata, 32'h0);
        step();
        chkb("rd_ack_n1", reg_ack, 1'b0);
        chk("rd_rdata_n1", reg_rdata, 32'h0);
        step();
        chkb("rd_ack_n2", reg_ack, 1'b1);
        chk("rd_data", reg_rdata, want);
        reg_req = 1'b0;
        step();
        chkb("rd_ack_drop", reg_ack, 1'b0);
        chk("rd_rdata_after", reg_rdata, 32'h0);
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 6))
            0, 1, 2: return 32'd64 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            3:       return 32'd4092 + 32'($urandom_range(0, 3));
            4:       return 32'($urandom_range(0, 63));
            5:       return 32'd4096 + 32'($urandom_range(0, 4095));
            default: return 32'hFFFF_FFFC;
        endcase
    endfunction

    initial begin
        logic        pv, ds, acked;
        logic [31:0] pa;
        logic [11:0] oor_addr;

        vt[0] = '{1'b1, 12'd64,   32'hA5A5_1234, 4'hF, 32'h0};
        vt[1] = '{1'b0, 12'd64,   32'h0,         4'h0, 32'hA5A5_1234};
        vt[2] = '{1'b1, 12'd68,   32'hFFFF_FFFF, 4'hF, 32'h0};
        vt[3] = '{1'b1, 12'd68,   32'h0000_0000, 4'h2, 32'h0};
        vt[4] = '{1'b0, 12'd68,   32'h0,         4'h0, 32'hFFFF_00FF};
        vt[5] = '{1'b1, 12'd4092, 32'h1234_5678, 4'hF, 32'h0};
        vt[6] = '{1'b0, 12'd4095, 32'h0,         4'h0, 32'h1234_5678};
        vt[7] = '{1'b1, 12'd72,   32'h0000_0000, 4'hF, 32'h0};
        vt[8] = '{1'b1, 12'd72,   32'hCAFE_F00D, 4'h5, 32'h0};
        vt[9] = '{1'b0, 12'd74,   32'h0,         4'h0, 32'h00FE_000D};

        reset = 1'b1; reg_req = 1'b0; reg_write_en = 1'b0; reg_addr = '0;
        reg_wdata = '0; reg_wstrb = '0; param_addr_valid = 1'b0; param_addr = '0;
        param_data_stop = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        chkb("rst_ack", reg_ack, 1'b0);
        chk("rst_rdata", reg_rdata, 32'h0);
        chkb("rst_pdv", param_data_valid, 1'b0);
        chk("rst_pdata", param_data, 32'h0);
        chkb("rst_astop", param_addr_stop, 1'b0);
        step();

        for (int i = 0; i < 10; i++) begin
            if (vt[i].wr) reg_write(vt[i].addr, vt[i].wdata, vt[i].wstrb);
            else          reg_read(vt[i].addr, vt[i].want);
        end

        // Out-of-range requests: 32 is below the window, 4096 wraps to 0 in 12 bits.
        for (int k = 0; k < 2; k++) begin
            oor_addr = (k == 0) ? 12'd32 : 12'd0;
            reg_req = 1'b1; reg_write_en = 1'b1; reg_addr = oor_addr;
            reg_wdata = 32'hDEAD_DEAD; reg_wstrb = 4'hF;
            #1;
            chkb("oor_astop", param_addr_stop, 1'b0);
            acked = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (reg_ack) acked = 1'b1;
                step();
            end
            chkb("oor_no_ack", acked, 1'b0);
            reg_req = 1'b0;
            step();
        end
        reg_read(12'd64, 32'hA5A5_1234);
        reg_read(12'd68, 32'hFFFF_00FF);

        for (int k = 0; k < 4; k++) reg_write(12'(64 + 4 * k), 32'(k + 1), 4'hF);

        // Back-to-back lookups at full rate.
        param_addr_valid = 1'b1; param_addr = 32'd64;
        #1;
        chkb("str_astop0", param_addr_stop, 1'b0);
        chkb("str_pdv0", param_data_valid, 1'b0);
        step();
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) param_addr = 32'(64 + 4 * k);
            else       param_addr_valid = 1'b0;
            #1;
            chkb("str_pdv", param_data_valid, 1'b1);
            chk("str_data", param_data, 32'(k));
            step();
        end
        chkb("str_pdv_end", param_data_valid, 1'b0);

        // Stalled result held while the register port reads the RAM meanwhile.
        param_addr_valid = 1'b1; param_addr = 32'd68; param_data_stop = 1'b1;
        step();
        param_addr = 32'd72;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin reg_req = 1'b1; reg_write_en = 1'b0; reg_addr = 12'd76; end
            #1;
            chkb("hold_pdv", param_data_valid, 1'b1);
            chk("hold_data", param_data, 32'd2);
            chkb("hold_astop", param_addr_stop, 1'b1);
            if (i == 2) begin
                chkb("hold_reg_ack", reg_ack, 1'b1);
                chk("hold_reg_rdata", reg_rdata, 32'd4);
                reg_req = 1'b0;
            end
            step();
        end
        param_data_stop = 1'b0;
        #1;
        chk("hold_release_data", param_data, 32'd2);
        chkb("hold_release_astop", param_addr_stop, 1'b0);
        step();
        param_addr_valid = 1'b0;
        #1;
        chk("hold_next_data", param_data, 32'd3);
        step();

        // Simultaneous register read and lookup: register port first.
        reg_req = 1'b1; reg_write_en = 1'b0; reg_addr = 12'd64;
        param_addr_valid = 1'b1; param_addr = 32'd76;
        #1;
        chkb("arb_astop_n", param_addr_stop, 1'b1);
        step();
        chkb("arb_astop_rd", param_addr_stop, 1'b1);
        step();
        chkb("arb_ack", reg_ack, 1'b1);
        chk("arb_rdata", reg_rdata, 32'd1);
        chkb("arb_astop_ack", param_addr_stop, 1'b1);
        reg_req = 1'b0;
        step();
        chkb("arb_astop_idle", param_addr_stop, 1'b0);
        chkb("arb_pdv_idle", param_data_valid, 1'b0);
        step();
        param_addr_valid = 1'b0;
        chkb("arb_pdv", param_data_valid, 1'b1);
        chk("arb_data", param_data, 32'd4);
        step();

        // Reset in RD with a stalled result pending.
        param_addr_valid = 1'b1; param_addr = 32'd64; param_data_stop = 1'b1;
        step();
        param_addr_valid = 1'b0;
        reg_req = 1'b1; reg_write_en = 1'b0; reg_addr = 12'd68;
        step();
        reset = 1'b1;
        #1;
        chkb("arst_pdv", param_data_valid, 1'b0);
        chkb("arst_ack", reg_ack, 1'b0);
        chk("arst_data", param_data, 32'h0);
        step();
        chkb("arst_ack_edge", reg_ack, 1'b0);
        reg_req = 1'b0; reset = 1'b0; param_data_stop = 1'b0;
        step();
        chkb("arst_ack_after", reg_ack, 1'b0);
        step();
        chkb("arst_pdv_after", param_data_valid, 1'b0);
        reg_read(12'd68, 32'd2);

        for (int k = 4; k < 8; k++) reg_write(12'(64 + 4 * k), $urandom, 4'hF);

        // Randomized lookup traffic against the model queue.
        q.delete();
        for (int c = 0; c < 400; c++) begin
            pv = ($urandom_range(0, 3) != 0);
            ds = ($urandom_range(0, 2) == 0);
            pa = pick_addr();
            param_addr_valid = pv; param_addr = pa; param_data_stop = ds;
            #1;
            chkb("rnd_pdv", param_data_valid, q.size() != 0);
            if (q.size() != 0) chk("rnd_data", param_data, q[0]);
            chkb("rnd_astop", param_addr_stop, (q.size() != 0) && ds);
            if (q.size() != 0 && !ds) void'(q.pop_front());
            if (pv && !param_addr_stop) q.push_back(exp_word(pa));
            step();
        end
        param_addr_valid = 1'b0; param_data_stop = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (q.size() == 0) break;
            #1;
            chk("drain_data", param_data, q[0]);
            void'(q.pop_front());
            step();
        end
        chk("drain_empty", 32'(q.size()), 32'h0);
        #1;
        chkb("drain_pdv", param_data_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
